gamepad_pmod_emulator: RTL and testbench

- Transmit side of the Gamepad Pmod 3-wire serial interface (data/clk/latch).
- Serialises a parallel 12- or 24-bit button word into pmod_data/pmod_clk/pmod_latch frames that gamepad_pmod_driver accepts unchanged.
- Used for loopback self-test and for driving on-board/simulated controllers.
- Frames are requested through a valid/ready handshake.

---
 rtl/gamepad_pmod_emulator.sv | 123 ++++++++++++
 tb/tb_gamepad_pmod_emulator.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gamepad_pmod_emulator.sv
// Gamepad Pmod transmitter: serialises a button word into data/clk/latch frames
// on a valid/ready request, for loopback self-test and simulated controllers.
module gamepad_pmod_emulator #(
    parameter int unsigned BIT_WIDTH   = 12,
    parameter int unsigned HALF_PERIOD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 pmod_data,
    output logic                 pmod_clk,
    output logic                 pmod_latch
);
    localparam int unsigned DIV_W = $clog2(HALF_PERIOD);
    localparam int unsigned BIT_W = $clog2(BIT_WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLK_HI,
        S_CLK_LO,
        S_LATCH,
        S_GAP
    } state_e;

    state_e               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [BIT_WIDTH-1:0] shift_q, shift_d;
    logic                 pmod_data_q, pmod_data_d;
    logic                 pmod_clk_q, pmod_clk_d;
    logic                 pmod_latch_q, pmod_latch_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 div_last;
    logic [BIT_W-1:0]     bit_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            pmod_data_q  <= 1'b0;
            pmod_clk_q   <= 1'b0;
            pmod_latch_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            pmod_data_q  <= pmod_data_d;
            pmod_clk_q   <= pmod_clk_d;
            pmod_latch_q <= pmod_latch_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    // Next state; outputs are derived from the next state so they change with it.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        div_last = (div_q == DIV_LAST);
        bit_inc  = bit_q + BIT_W'(1);

        if (state_q != S_IDLE) begin
            div_d = div_last ? '0 : div_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    shift_d = in_data;
                    bit_d   = '0;
                    div_d   = '0;
                    state_d = S_CLK_HI;
                end
            end
            S_CLK_HI: begin
                if (div_last) state_d = S_CLK_LO;
            end
            S_CLK_LO: begin
                if (div_last) begin
                    shift_d = {shift_q[BIT_WIDTH-2:0], 1'b0};
                    bit_d   = bit_inc;
                    state_d = (bit_inc == BIT_LAST) ? S_LATCH : S_CLK_HI;
                end
            end
            S_LATCH: begin
                if (div_last) state_d = S_GAP;
            end
            S_GAP: begin
                if (div_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Data follows the MSB only while a bit is on the wire; shift happens as CLK_LO exits.
        pmod_clk_d   = (state_d == S_CLK_HI);
        pmod_latch_d = (state_d == S_LATCH);
        pmod_data_d  = ((state_d == S_CLK_HI) || (state_d == S_CLK_LO)) && shift_d[BIT_WIDTH-1];
        done_d       = (state_d == S_GAP) && (div_d == DIV_LAST);
        busy_d       = (state_d != S_IDLE);
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign pmod_data  = pmod_data_q;
    assign pmod_clk   = pmod_clk_q;
    assign pmod_latch = pmod_latch_q;

endmodule

// File: tb/tb_gamepad_pmod_emulator.sv
// Bench for gamepad_pmod_emulator: two instances (12-bit/HP4, 24-bit/HP3) checked
// every cycle against a frame-timeline model plus a behavioural Pmod receiver.
module tb_gamepad_pmod_emulator;
    localparam int BW0 = 12;
    localparam int HP0 = 4;
    localparam int BW1 = 24;
    localparam int HP1 = 3;

    logic        clk;
    logic        rst;
    logic        vld0, vld1;
    logic [11:0] d0;
    logic [23:0] d1;
    logic        rdy0, bsy0, fd0, pd0, pc0, pl0;
    logic        rdy1, bsy1, fd1, pd1, pc1, pl1;
    logic [5:0]  act [2];

    gamepad_pmod_emulator #(.BIT_WIDTH(BW0), .HALF_PERIOD(HP0)) dut0 (
        .clk(clk), .rst(rst), .in_data(d0), .in_valid(vld0), .in_ready(rdy0),
        .busy(bsy0), .frame_done(fd0), .pmod_data(pd0), .pmod_clk(pc0), .pmod_latch(pl0)
    );
    gamepad_pmod_emulator #(.BIT_WIDTH(BW1), .HALF_PERIOD(HP1)) dut1 (
        .clk(clk), .rst(rst), .in_data(d1), .in_valid(vld1), .in_ready(rdy1),
        .busy(bsy1), .frame_done(fd1), .pmod_data(pd1), .pmod_clk(pc1), .pmod_latch(pl1)
    );

    // {data, clk, latch, done, busy, ready}
    assign act[0] = {pd0, pc0, pl0, fd0, bsy0, rdy0};
    assign act[1] = {pd1, pc1, pl1, fd1, bsy1, rdy1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: t = cycles since the accept edge (0 = idle), word = frame being sent.
    int          t       [2] = '{0, 0};
    logic [23:0] word    [2] = '{default: '0};
    int          acc_cyc [2] = '{0, 0};
    int          acc_n   [2] = '{0, 0};
    int          cyc = 0;

    function automatic int bw_of(input int i);
        return (i == 0) ? BW0 : BW1;
    endfunction
    function automatic int hp_of(input int i);
        return (i == 0) ? HP0 : HP1;
    endfunction
    function automatic int flen(input int i);
        return 2 * hp_of(i) * bw_of(i) + 2 * hp_of(i);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                t[i] <= 0;
            end else if (t[i] == 0) begin
                if ((i == 0) ? vld0 : vld1) begin
                    t[i]       <= 1;
                    word[i]    <= (i == 0) ? {12'h000, d0} : d1;
                    acc_cyc[i] <= cyc;
                    acc_n[i]   <= acc_n[i] + 1;
                end
            end else if (t[i] == flen(i)) begin
                t[i] <= 0;
            end else begin
                t[i] <= t[i] + 1;
            end
        end
        cyc <= cyc + 1;
    end

    // Expected outputs from the frame timeline: BW bits of (HP high, HP low), then HP latch, HP gap.
    function automatic logic [5:0] exp_out(input int i);
        int bw, hp, p, q;
        logic b;
        bw = bw_of(i);
        hp = hp_of(i);
        if (rst || t[i] == 0) return 6'b000001;
        p = t[i] - 1;
        if (p < 2 * hp * bw) begin
            b = word[i][bw - 1 - p / (2 * hp)];
            return {b, (p % (2 * hp)) < hp, 1'b0, 1'b0, 1'b1, 1'b0};
        end
        q = p - 2 * hp * bw;
        return {1'b0, 1'b0, q < hp, q == 2 * hp - 1, 1'b1, 1'b0};
    endfunction

    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] sh        [2] = '{default: '0};
    logic [23:0] rx        [2] = '{default: '0};
    logic        pclk_prev [2] = '{1'b0, 1'b0};
    logic        plat_prev [2] = '{1'b0, 1'b0};
    int          fall_n    [2] = '{0, 0};
    int          lat_n     [2] = '{0, 0};
    int          lat_tot   [2] = '{0, 0};
    int          done_n    [2] = '{0, 0};
    int          lat_at    [2] = '{-1, -1};
    int          done_at   [2] = '{-1, -1};
    int          run       [2] = '{0, 0};
    int          last_run  [2] = '{0, 0};

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Per-cycle trace compare plus a receiver: shift on pmod_clk fall, load on latch rise.
    task automatic monitor();
        logic [5:0]  e;
        logic [23:0] m;
        for (int i = 0; i < 2; i++) begin
            e = exp_out(i);
            m = (i == 0) ? 24'h000FFF : 24'hFFFFFF;
            check($sformatf("trace%0d", i), 24'(act[i]), 24'(e));
            if (t[i] == 1) begin
                fall_n[i]  = 0;
                lat_n[i]   = 0;
                lat_at[i]  = -1;
                done_at[i] = -1;
            end
            if (pclk_prev[i] && !act[i][4]) begin
                fall_n[i]++;
                sh[i] = {sh[i][22:0], act[i][5]};
            end
            if (!plat_prev[i] && act[i][3]) begin
                lat_n[i]++;
                lat_tot[i]++;
                rx[i] = sh[i] & m;
                if (lat_at[i] < 0) lat_at[i] = cyc - acc_cyc[i];
            end
            if (act[i][2]) begin
                done_n[i]++;
                done_at[i] = cyc - acc_cyc[i];
                check($sformatf("rx%0d", i), rx[i], word[i] & m);
                check($sformatf("falls%0d", i), 24'(fall_n[i]), 24'(bw_of(i)));
                check($sformatf("latches%0d", i), 24'(lat_n[i]), 24'd1);
            end
            if (act[i][0]) begin
                run[i]++;
            end else if (run[i] != 0) begin
                last_run[i] = run[i];
                run[i]      = 0;
            end
            pclk_prev[i] = act[i][4];
            plat_prev[i] = act[i][3];
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int i);
        int n;
        n = 0;
        while (t[i] != 0 && n < 2000) begin
            tick();
            n++;
        end
        check($sformatf("done_in_time%0d", i), 24'(t[i] == 0), 24'd1);
    endtask

    task automatic send(input int i, input logic [23:0] w);
        wait_done(i);
        if (i == 0) begin
            vld0 = 1'b1;
            d0   = w[11:0];
        end else begin
            vld1 = 1'b1;
            d1   = w;
        end
        tick();
        vld0 = 1'b0;
        vld1 = 1'b0;
    endtask

    logic [11:0] b2b [3] = '{12'hFFF, 12'h000, 12'h801};
    int          n0, w, lt, dn;

    initial begin
        rst  = 1'b1;
        vld0 = 1'b0;
        vld1 = 1'b0;
        d0   = '0;
        d1   = '0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        check("idle0", 24'(act[0]), 24'h000001);
        check("idle1", 24'(act[1]), 24'h000001);

        // Single 12'hA5C frame with pinned timing.
        send(0, 24'h000A5C);
        wait_done(0);
        check("a5c_rx", rx[0], 24'h000A5C);
        check("a5c_latch_at", 24'(lat_at[0]), 24'd97);
        check("a5c_done_at", 24'(done_at[0]), 24'd104);
        check("a5c_ready_105", 24'(act[0][0]), 24'd1);
        check("a5c_busy_105", 24'(act[0][1]), 24'd0);

        // Back-to-back with in_valid held high.
        vld0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d0 = b2b[k];
            n0 = acc_n[0];
            w  = 0;
            while (acc_n[0] == n0 && w < 400) begin
                tick();
                w++;
            end
            check("b2b_accept", 24'(acc_n[0] - n0), 24'd1);
            if (k == 2) vld0 = 1'b0;
            tick();
            if (k > 0) check("b2b_gap", 24'(last_run[0]), 24'd1);
        end
        wait_done(0);
        check("b2b_last_rx", rx[0], 24'h000801);

        // 24-bit frame on the second instance.
        lt = lat_tot[1];
        send(1, 24'h123456);
        wait_done(1);
        check("w24_rx", rx[1], 24'h123456);
        check("w24_done_at", 24'(done_at[1]), 24'd150);
        check("w24_latch_pulses", 24'(lat_tot[1] - lt), 24'd1);

        // Reset in the middle of a frame leaves the receiver holding the previous word.
        send(0, 24'h0000F0);
        wait_done(0);
        check("pre_rst_rx", rx[0], 24'h0000F0);
        lt = lat_tot[0];
        send(0, 24'h0003C3);
        w = 0;
        while (t[0] != 40 && w < 200) begin
            tick();
            w++;
        end
        rst = 1'b1;
        #1;
        check("rst_outputs", 24'(act[0]), 24'h000001);
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("rst_no_latch", 24'(lat_tot[0] - lt), 24'd0);
        check("rst_rx_kept", rx[0], 24'h0000F0);
        send(0, 24'h0003C3);
        wait_done(0);
        check("post_rst_rx", rx[0], 24'h0003C3);

        // Requests and data churn while busy must not disturb the frame.
        dn = done_n[0];
        send(0, 24'h0005A3);
        while (t[0] != 0 && t[0] < 100) begin
            vld0 = 1'($urandom_range(0, 1));
            d0   = 12'($urandom);
            tick();
        end
        vld0 = 1'b0;
        wait_done(0);
        repeat (10) tick();
        check("busy_one_frame", 24'(done_n[0] - dn), 24'd1);
        check("busy_rx", rx[0], 24'h0005A3);

        // Random requests on both instances.
        for (int c = 0; c < 4000; c++) begin
            vld0 = ($urandom_range(0, 5) == 0);
            d0   = 12'($urandom);
            vld1 = ($urandom_range(0, 5) == 0);
            d1   = 24'($urandom);
            tick();
        end
        vld0 = 1'b0;
        vld1 = 1'b0;
        wait_done(0);
        wait_done(1);
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
